// File: rtl/sbus_arb_pkg.sv
// sbus_arb_pkg: shared types and constants for the serial-bus arbiter.
package sbus_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_OWN   = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } sbus_arb_state_e;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned REQ_SD  = 0;
  localparam int unsigned REQ_LCD = 1;

  localparam int unsigned DEF_SETUP_CYCLES   = 2;
  localparam int unsigned DEF_HOLD_CYCLES    = 2;
  localparam int unsigned DEF_GAP_CYCLES     = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 270000;

  // Largest of three phase lengths; sizes the shared phase counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sbus_arb_cnt.sv
// sbus_arb_cnt: loadable down-counter that saturates at zero, with a zero flag.
module sbus_arb_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero_c
);

  logic [W-1:0] r_count;

  // Load wins over counting; hold at zero until the next load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/sbus_arbiter.sv
// sbus_arbiter: round-robin owner of the shared SD/LCD serial bus, framing each
// ownership with CS setup, hold and inter-owner gap.
// Optional watchdog revoke and lockout: define SBUS_ARB_TIMEOUT_EN.
module sbus_arbiter
  import sbus_arb_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES   = DEF_SETUP_CYCLES,
  parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clk27,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] cs_n,
  output logic               sel,
  output logic               busy,
  output logic [NUM_REQ-1:0] timeout_flag,
  input  logic               timeout_clr
);

  localparam int unsigned PH_MAX = max3(SETUP_CYCLES, HOLD_CYCLES, GAP_CYCLES);
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

  sbus_arb_state_e    r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt, r_cs_n, w_gnt_nxt, w_cs_n_nxt;
  logic               r_sel, r_last, r_busy;
  logic               w_sel_nxt, w_last_nxt, w_busy_nxt;
  logic [NUM_REQ-1:0] w_elig, w_lock;
  logic               w_win, w_req_own, w_ph_zero, w_wd_zero, w_revoke;
  logic               w_ph_ld, w_wd_ld;
  logic [PH_W-1:0]    w_ph_ld_val;

  assign w_elig    = req & ~w_lock;
  assign w_req_own = req[r_sel];

  // Shared timer for SETUP, HOLD and GAP, reloaded on every state change.
  sbus_arb_cnt #(.W(PH_W)) u_ph_cnt (
    .i_clk      (clk27),
    .i_rst_n    (reset_n),
    .i_load     (w_ph_ld),
    .i_load_val (w_ph_ld_val),
    .o_zero_c   (w_ph_zero)
  );

  // Next state, arbitration, counter loads and next registered outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    w_revoke    = 1'b0;
    w_ph_ld     = 1'b0;
    w_ph_ld_val = '0;
    w_wd_ld     = 1'b0;
    w_gnt_nxt   = '0;
    w_cs_n_nxt  = '1;
    w_busy_nxt  = 1'b0;

    if (w_elig[REQ_SD] && w_elig[REQ_LCD]) begin
      w_win = ~r_last;
    end else begin
      w_win = w_elig[REQ_LCD];
    end

    case (r_state)
      ST_IDLE: begin
        if (|w_elig) begin
          w_state_nxt = ST_SETUP;
          w_sel_nxt   = w_win;
          w_last_nxt  = w_win;
        end
      end
      ST_SETUP: begin
        if (!w_req_own) begin
          w_state_nxt = ST_HOLD;
        end else if (w_ph_zero) begin
          w_state_nxt = ST_OWN;
        end
      end
      ST_OWN: begin
        // A release in the expiry cycle is a normal release, not a revoke.
        if (!w_req_own) begin
          w_state_nxt = ST_HOLD;
        end else if (w_wd_zero) begin
          w_state_nxt = ST_HOLD;
          w_revoke    = 1'b1;
        end
      end
      ST_HOLD: begin
        if (w_ph_zero) begin
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_ph_zero) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_state_nxt != r_state) begin
      w_ph_ld = 1'b1;
      w_wd_ld = (w_state_nxt == ST_OWN);
      case (w_state_nxt)
        ST_SETUP: w_ph_ld_val = PH_W'(SETUP_CYCLES - 32'd1);
        ST_HOLD:  w_ph_ld_val = PH_W'(HOLD_CYCLES - 32'd1);
        ST_GAP:   w_ph_ld_val = PH_W'(GAP_CYCLES - 32'd1);
        default:  w_ph_ld_val = '0;
      endcase
    end

    w_busy_nxt = (w_state_nxt != ST_IDLE);
    if ((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_OWN) || (w_state_nxt == ST_HOLD)) begin
      w_cs_n_nxt[w_sel_nxt] = 1'b0;
    end
    if (w_state_nxt == ST_OWN) begin
      w_gnt_nxt[w_sel_nxt] = 1'b1;
    end
  end

  // State and registered bus-control outputs.
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_cs_n  <= '1;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign gnt  = r_gnt;
  assign cs_n = r_cs_n;
  assign sel  = r_sel;
  assign busy = r_busy;

`ifdef SBUS_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [NUM_REQ-1:0] r_lock, r_tflag, w_lock_nxt, w_tflag_nxt;

  // Watchdog: expires after TIMEOUT_CYCLES cycles in OWN.
  sbus_arb_cnt #(.W(WD_W)) u_wd_cnt (
    .i_clk      (clk27),
    .i_rst_n    (reset_n),
    .i_load     (w_wd_ld),
    .i_load_val (WD_W'(TIMEOUT_CYCLES - 32'd1)),
    .o_zero_c   (w_wd_zero)
  );

  // Revoke sets flag and lockout; lockout clears once req is seen low; set beats clear.
  always_comb begin
    w_lock_nxt  = r_lock & req;
    w_tflag_nxt = timeout_clr ? '0 : r_tflag;
    if (w_revoke) begin
      w_lock_nxt[r_sel]  = 1'b1;
      w_tflag_nxt[r_sel] = 1'b1;
    end
  end

  // Lockout and sticky flag registers.
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      r_lock  <= '0;
      r_tflag <= '0;
    end else begin
      r_lock  <= w_lock_nxt;
      r_tflag <= w_tflag_nxt;
    end
  end

  assign w_lock       = r_lock;
  assign timeout_flag = r_tflag;
`else
  logic w_unused;

  assign w_wd_zero    = 1'b0;
  assign w_lock       = '0;
  assign timeout_flag = '0;
  assign w_unused     = ^{timeout_clr, w_wd_ld, w_revoke, 32'(TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_sbus_arbiter.sv
// tb_sbus_arbiter: directed scenarios plus random req traffic, checked every
// cycle against a phase/age reference model of the arbiter.
module tb_sbus_arbiter;

  localparam int SETUP = 2;
  localparam int HOLD  = 2;
  localparam int GAP   = 4;
  localparam int TMO   = 16;
`ifdef SBUS_ARB_TIMEOUT_EN
  localparam bit TE = 1'b1;
`else
  localparam bit TE = 1'b0;
`endif

  localparam int P_IDLE  = 0;
  localparam int P_SETUP = 1;
  localparam int P_OWN   = 2;
  localparam int P_HOLD  = 3;
  localparam int P_GAP   = 4;

  logic       clk27 = 1'b0;
  logic       reset_n = 1'b1;
  logic [1:0] req = 2'b00;
  logic       timeout_clr = 1'b0;
  logic [1:0] gnt, cs_n, timeout_flag;
  logic       sel, busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase name, cycles spent in it, owner, last owner, lockout, flags.
  int         m_ph, m_age, m_own, m_last;
  logic [1:0] m_lock, m_flag;

  sbus_arbiter #(
    .SETUP_CYCLES   (SETUP),
    .HOLD_CYCLES    (HOLD),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk27        (clk27),
    .reset_n      (reset_n),
    .req          (req),
    .gnt          (gnt),
    .cs_n         (cs_n),
    .sel          (sel),
    .busy         (busy),
    .timeout_flag (timeout_flag),
    .timeout_clr  (timeout_clr)
  );

  always #5 clk27 = ~clk27;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_ph = P_IDLE; m_age = 0; m_own = 0; m_last = 1;
    m_lock = 2'b00; m_flag = 2'b00;
  endtask

  task automatic m_enter(input int ph);
    m_ph  = ph;
    m_age = 1;
  endtask

  // One clock edge of the model, given the inputs present at that edge.
  task automatic m_step(input logic [1:0] r, input logic c);
    logic [1:0] el, set;
    el  = r & ~m_lock;
    set = 2'b00;
    case (m_ph)
      P_IDLE: if (el != 2'b00) begin
        m_own  = (el == 2'b11) ? 1 - m_last : (el[1] ? 1 : 0);
        m_last = m_own;
        m_enter(P_SETUP);
      end
      P_SETUP: if (!r[m_own]) m_enter(P_HOLD);
               else if (m_age >= SETUP) m_enter(P_OWN);
               else m_age++;
      P_OWN: if (!r[m_own]) m_enter(P_HOLD);
             else if (TE && m_age >= TMO) begin set[m_own] = 1'b1; m_enter(P_HOLD); end
             else m_age++;
      P_HOLD: if (m_age >= HOLD) m_enter(P_GAP); else m_age++;
      default: if (m_age >= GAP) m_enter(P_IDLE); else m_age++;
    endcase
    m_lock = (m_lock & r) | set;
    m_flag = (c ? 2'b00 : m_flag) | set;
  endtask

  function automatic logic [7:0] m_exp();
    logic [1:0] g, cs;
    g  = 2'b00;
    cs = 2'b11;
    if (m_ph == P_OWN) g[m_own] = 1'b1;
    if (m_ph == P_SETUP || m_ph == P_OWN || m_ph == P_HOLD) cs[m_own] = 1'b0;
    return {g, cs, m_own[0], (m_ph != P_IDLE), m_flag};
  endfunction

  // Advance one cycle, step the model, compare all outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk27);
    m_step(req, timeout_clr);
    #1;
    chk("model", 32'({gnt, cs_n, sel, busy, timeout_flag}), 32'(m_exp()));
    chk("cs_both_low", 32'(cs_n == 2'b00), 32'(0));
  endtask

  // Mid-cycle asynchronous reset: outputs must clear without waiting for a clock.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    m_reset();
    #1;
    chk("rst_outputs", 32'({gnt, cs_n, sel, busy, timeout_flag}), 32'(8'b00_11_0_0_00));
    repeat (2) @(posedge clk27);
    #3 reset_n = 1'b1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64 && busy; i++) tick();
    chk("idle_wait", 32'(busy), 32'(0));
  endtask

  task automatic wait_gnt(input string tag);
    for (int i = 0; i < 64 && gnt == 2'b00; i++) tick();
    chk(tag, 32'(gnt != 2'b00), 32'(1));
  endtask

  initial begin
    int ngr, gap, olen;
    m_reset();
    do_reset();

    // Single SD ownership: latency from req rise and from req drop.
    req = 2'b01; tick();
    chk("t1_setup_cs", 32'(cs_n), 32'(2'b10));
    chk("t1_setup_busy", 32'(busy), 32'(1));
    tick(); chk("t1_gnt_early", 32'(gnt), 32'(0));
    tick(); chk("t1_gnt", 32'(gnt), 32'(2'b01));
    repeat (5) tick();
    req = 2'b00; tick();
    chk("t1_gnt_drop", 32'(gnt), 32'(0));
    chk("t1_hold_cs", 32'(cs_n), 32'(2'b10));
    tick(); tick();
    chk("t1_cs_rel", 32'(cs_n), 32'(2'b11));
    repeat (3) tick(); chk("t1_busy_gap", 32'(busy), 32'(1));
    tick(); chk("t1_idle", 32'(busy), 32'(0));

    // Both requesting, each owner releasing briefly: strict alternation and fixed gap.
    do_reset();
    req = 2'b11; ngr = 0; gap = 0; olen = 0;
    for (int c = 0; c < 300 && ngr < 4; c++) begin
      tick();
      if (gnt != 2'b00) begin
        if (olen == 0) begin
          ngr++;
          chk("alt_owner", 32'(gnt), 32'((ngr % 2 == 1) ? 2'b01 : 2'b10));
          if (ngr > 1) chk("alt_gap", 32'(gap), 32'(HOLD + GAP + 1 + SETUP));
        end
        olen++;
        if (olen == 3) req = gnt[0] ? 2'b10 : 2'b01;
      end else begin
        if (olen != 0) gap = 0;
        olen = 0;
        gap++;
        req = 2'b11;
      end
    end
    chk("alt_count", 32'(ngr), 32'(4));
    req = 2'b00; wait_idle();

    // Request withdrawn during SETUP: no grant, CS released after HOLD.
    req = 2'b10; tick(); chk("t3_setup_cs", 32'(cs_n), 32'(2'b01));
    req = 2'b00; tick();
    chk("t3_no_gnt", 32'(gnt), 32'(0));
    chk("t3_hold_cs", 32'(cs_n), 32'(2'b01));
    tick(); chk("t3_hold_cs2", 32'(cs_n), 32'(2'b01));
    tick(); chk("t3_cs_rel", 32'(cs_n), 32'(2'b11));
    wait_idle();

`ifdef SBUS_ARB_TIMEOUT_EN
    // Watchdog revoke, lockout until req toggles, flag clear and set-beats-clear.
    req = 2'b01; wait_gnt("t4_gnt"); olen = 1;
    for (int i = 0; i < 40 && gnt != 2'b00; i++) begin
      tick();
      if (gnt != 2'b00) olen++;
    end
    chk("t4_own_len", 32'(olen), 32'(TMO));
    chk("t4_flag", 32'(timeout_flag), 32'(2'b01));
    wait_idle();
    repeat (5) tick(); chk("t4_locked", 32'(busy), 32'(0));
    req = 2'b11; tick(); chk("t4_other_cs", 32'(cs_n), 32'(2'b01));
    wait_gnt("t4_other_gnt"); chk("t4_other_owner", 32'(gnt), 32'(2'b10));
    req = 2'b01; wait_idle();
    repeat (5) tick(); chk("t4_still_locked", 32'(busy), 32'(0));
    req = 2'b00; tick();
    req = 2'b01; tick(); chk("t4_regrant_cs", 32'(cs_n), 32'(2'b10));
    timeout_clr = 1'b1; tick(); timeout_clr = 1'b0;
    chk("t4_clr", 32'(timeout_flag), 32'(0));
    wait_gnt("t4_gnt2"); olen = 1;
    for (int i = 0; i < 40 && olen < TMO; i++) begin tick(); olen++; end
    timeout_clr = 1'b1; tick(); timeout_clr = 1'b0;
    chk("t4_coinc_gnt", 32'(gnt), 32'(0));
    chk("t4_coinc_flag", 32'(timeout_flag), 32'(2'b01));
    req = 2'b00; wait_idle();
`else
    // No ownership limit; flag stays low even when clear is pulsed.
    req = 2'b01; wait_gnt("t4_gnt");
    repeat (3 * TMO) tick();
    chk("t4_no_limit", 32'(gnt), 32'(2'b01));
    timeout_clr = 1'b1; tick(); timeout_clr = 1'b0;
    chk("t4_flag_tied", 32'(timeout_flag), 32'(0));
    req = 2'b00; wait_idle();
`endif

    // Async reset during OWN, then requester 0 must win the first tie.
    req = 2'b01; wait_gnt("t5_gnt"); tick();
    req = 2'b11;
    do_reset();
    tick(); chk("t5_tie_cs", 32'(cs_n), 32'(2'b10));
    chk("t5_tie_sel", 32'(sel), 32'(0));

    // Random request/clear traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      tick();
      if ($urandom_range(0, 19) == 0) req[0] = ~req[0];
      if ($urandom_range(0, 19) == 0) req[1] = ~req[1];
      timeout_clr = ($urandom_range(0, 29) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
